spi_xip_ctrl: RTL and testbench
===============================

SPI_XIP_CTRL -- requirements
Module: spi_xip_ctrl

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03: flash read opcode sent as the first byte.
REQ-002 SHALL have parameter CTRL_WORD, default 32'h0000_2240: CTRL image with char_len=64, ASS=1 and GO=0.
REQ-003 SHALL have parameter GO_BIT, default 8: bit index of GO in CTRL.
REQ-004 SHALL have parameter POLL_MAX, default 16'd1024: maximum number of CTRL polls before timeout.
REQ-005 clk  in  1  single clock, also drives the SPI peripheral's PCLK.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 req_valid  in  1; req_ready  out  1; req_addr  in  24  read-request handshake and byte address.
REQ-008 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  32; rsp_err  out  1  response handshake.
REQ-009 paddr  out  5; psel  out  1; penable  out  1; pwrite  out  1; pwdata  out  32  APB master request.
REQ-010 prdata  in  32; pready  in  1; pslverr  in  1  APB master completion.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS and RESP; a step register SHALL select one of WR_TX1, WR_TX0, WR_CFG, WR_GO, RD_POLL and RD_RX.
REQ-013 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready the block latches req_addr, sets step=WR_TX1, clears the poll count and enters SETUP next cycle.
REQ-014 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-015 ACCESS SHALL drive psel=1, penable=1 and hold paddr, pwrite and pwdata stable until pready=1.
REQ-016 In every other state psel and penable SHALL be 0, and paddr, pwrite and pwdata are don't-care.
REQ-017 Step sequence (paddr/pwrite/pwdata):
- WR_TX1: 0x04 / 1 / {READ_CMD, addr}
- WR_TX0: 0x00 / 1 / 0
- WR_CFG: 0x10 / 1 / CTRL_WORD with GO cleared
- WR_GO: 0x10 / 1 / CTRL_WORD with GO set
- RD_POLL: 0x10 / 0
- RD_RX: 0x00 / 0
REQ-018 On pready=1 with pslverr=0, the next step SHALL follow REQ-017 and SETUP SHALL begin the next cycle.
- Minimum is 3 cycles per access against the 1-wait peripheral.
REQ-019 RD_POLL, prdata[GO_BIT]=1: SHALL increment the poll count and repeat RD_POLL.
REQ-020 RD_POLL, prdata[GO_BIT]=0: SHALL advance to RD_RX.
REQ-021 RD_RX completion SHALL capture prdata into rsp_data unmodified, with no byte swap, and enter RESP with rsp_err=0.
REQ-022 pready=1 with pslverr=1 at any step SHALL abort the sequence: enter RESP with rsp_err=1 and rsp_data=0.
REQ-023 If the poll count reaches POLL_MAX with GO still set, the block SHALL enter RESP with rsp_err=1 and rsp_data=0, issuing no further APB access.
REQ-024 RESP SHALL hold rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE next cycle; a new request is accepted no earlier than that IDLE cycle.
REQ-025 req_valid asserted while busy SHALL be ignored; it is neither accepted nor queued.
REQ-026 The 24-bit address SHALL be sent unmodified, with no alignment check; poll count is 16 bits and saturates at POLL_MAX.

Reset
REQ-027 While rst=1 at a clk edge:
- state=IDLE, step=WR_TX1, poll count=0.
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- req_ready=0 during reset, 1 in the first cycle after.
- rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
REQ-028 Reset mid-operation SHALL drop psel/penable the cycle after the reset edge with no response produced; SPI peripheral recovery is via its own reset in the same domain.

Verification
REQ-029 Read, addr=24'h001234, slave GO clears on 3rd poll, RX_0=32'hDEADBEEF:
- Writes seen: 0x04=32'h03001234, 0x00=0, 0x10=CTRL_WORD, 0x10=CTRL_WORD|32'h100.
- Then 3 CTRL reads, then 1 RX_0 read.
- rsp_valid with rsp_data=32'hDEADBEEF, rsp_err=0.
REQ-030 pslverr=1 on WR_GO access:
- No further APB access.
- rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-031 GO never clears, POLL_MAX=4:
- Exactly 4 CTRL reads, then rsp_err=1.
REQ-032 rsp_ready held 0 for 5 cycles:
- rsp_valid and rsp_data stable throughout.
- req_ready=0 until the cycle after the rsp_ready handshake.
REQ-033 Second req_valid during busy with addr=24'hABCDEF:
- Ignored; no TX_1 write with 32'h03ABCDEF until it is re-presented in IDLE.
REQ-034 rst pulsed for 1 cycle during ACCESS of RD_POLL:
- psel=0 next cycle.
- No rsp_valid.
- req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/spi_xip_ctrl.sv
// Execute-in-place read engine: turns a 24-bit byte-address read request into an
// APB register sequence on an SPI master peripheral and returns the 32-bit RX word.
module spi_xip_ctrl #(
   parameter logic [7:0]  READ_CMD  = 8'h03,
   parameter logic [31:0] CTRL_WORD = 32'h0000_2240,
   parameter int unsigned GO_BIT    = 8,
   parameter logic [15:0] POLL_MAX  = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [4:0]  paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic        busy
);

   localparam logic [4:0]  AddrRx   = 5'h00;
   localparam logic [4:0]  AddrTx1  = 5'h04;
   localparam logic [4:0]  AddrCtrl = 5'h10;
   localparam logic [4:0]  GoIdx    = GO_BIT[4:0];
   localparam logic [31:0] GoMask   = 32'd1 << GoIdx;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;
   typedef enum logic [2:0] {
      StepWrTx1, StepWrTx0, StepWrCfg, StepWrGo, StepRdPoll, StepRdRx
   } step_e;

   state_e      state_q;
   step_e       step_q;
   step_e       step_d;
   logic [23:0] addr_q;
   logic [23:0] addr_d;
   logic [15:0] poll_q;
   logic [15:0] poll_inc;
   logic        ready_q;
   logic        psel_q;
   logic        penable_q;
   logic        pwrite_q;
   logic [4:0]  paddr_q;
   logic [31:0] pwdata_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_data_q;

   logic        accept;
   logic        done;
   logic        go_set;
   logic        poll_timeout;
   logic [4:0]  nx_paddr;
   logic        nx_pwrite;
   logic [31:0] nx_pwdata;

   assign accept   = (state_q == StIdle) && ready_q && req_valid;
   assign done     = (state_q == StAccess) && pready;
   assign go_set   = prdata[GoIdx];
   assign addr_d   = accept ? req_addr : addr_q;
   assign poll_inc = (poll_q >= POLL_MAX) ? POLL_MAX : poll_q + 16'd1;
   // Timeout fires on the poll that brings the count up to POLL_MAX with GO still set.
   assign poll_timeout = (step_q == StepRdPoll) && go_set && (poll_inc >= POLL_MAX);

   always_comb begin
      step_d = step_q;
      if (accept) begin
         step_d = StepWrTx1;
      end else if (done && !pslverr) begin
         unique case (step_q)
            StepWrTx1:  step_d = StepWrTx0;
            StepWrTx0:  step_d = StepWrCfg;
            StepWrCfg:  step_d = StepWrGo;
            StepWrGo:   step_d = StepRdPoll;
            StepRdPoll: step_d = go_set ? StepRdPoll : StepRdRx;
            StepRdRx:   step_d = StepRdRx;
            default:    step_d = step_q;
         endcase
      end
   end

   always_comb begin
      nx_paddr  = AddrCtrl;
      nx_pwrite = 1'b0;
      nx_pwdata = '0;
      unique case (step_d)
         StepWrTx1: begin
            nx_paddr  = AddrTx1;
            nx_pwrite = 1'b1;
            nx_pwdata = {READ_CMD, addr_d};
         end
         StepWrTx0: begin
            nx_paddr  = AddrRx;
            nx_pwrite = 1'b1;
         end
         StepWrCfg: begin
            nx_paddr  = AddrCtrl;
            nx_pwrite = 1'b1;
            nx_pwdata = CTRL_WORD & ~GoMask;
         end
         StepWrGo: begin
            nx_paddr  = AddrCtrl;
            nx_pwrite = 1'b1;
            nx_pwdata = CTRL_WORD | GoMask;
         end
         StepRdPoll: nx_paddr = AddrCtrl;
         StepRdRx:   nx_paddr = AddrRx;
         default:    nx_paddr = AddrCtrl;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         step_q      <= StepWrTx1;
         addr_q      <= '0;
         poll_q      <= '0;
         ready_q     <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q   <= 1'b0;
                  addr_q    <= req_addr;
                  step_q    <= step_d;
                  poll_q    <= '0;
                  state_q   <= StSetup;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  paddr_q   <= nx_paddr;
                  pwrite_q  <= nx_pwrite;
                  pwdata_q  <= nx_pwdata;
               end
            end
            StSetup: begin
               penable_q <= 1'b1;
               state_q   <= StAccess;
            end
            StAccess: begin
               if (pready) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (pslverr || poll_timeout) begin
                     if (poll_timeout) begin
                        poll_q <= poll_inc;
                     end
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                  end else if (step_q == StepRdRx) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= prdata;
                  end else begin
                     if ((step_q == StepRdPoll) && go_set) begin
                        poll_q <= poll_inc;
                     end
                     step_q    <= step_d;
                     state_q   <= StSetup;
                     psel_q    <= 1'b1;
                     paddr_q   <= nx_paddr;
                     pwrite_q  <= nx_pwrite;
                     pwdata_q  <= nx_pwdata;
                  end
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign busy      = (state_q != StIdle);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Bench for spi_xip_ctrl: one-wait-state APB SPI peripheral model, table of read
// vectors, and directed sequences for backpressure, ignored requests and reset.
module tb_spi_xip_ctrl;

   localparam logic [31:0] CTRL = 32'h0000_2240;
   localparam logic [31:0] GO   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [4:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata  = '0;
   logic        pready  = 1'b0;
   logic        pslverr = 1'b0;
   logic        busy;

   always #5 clk = ~clk;

   spi_xip_ctrl #(.POLL_MAX(16'd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   int          go_polls   = 0;
   int          err_idx    = -1;
   int          ctrl_reads = 0;
   logic [31:0] rx_word    = '0;

   logic [4:0]  log_addr [64];
   logic        log_wr   [64];
   logic [31:0] log_data [64];
   int          n_log = 0;

   // Peripheral: one wait cycle in ACCESS, then completes.
   initial begin : slave
      int waited;
      waited = 0;
      forever begin
         @(negedge clk);
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = '0;
         if (psel && penable) begin
            if (waited == 0) begin
               waited = 1;
            end else begin
               waited = 0;
               pready = 1'b1;
               if (n_log == err_idx) pslverr = 1'b1;
               if (!pwrite && paddr == 5'h10) begin
                  prdata = CTRL | ((ctrl_reads < go_polls) ? GO : 32'h0);
                  ctrl_reads++;
               end else if (!pwrite && paddr == 5'h00) begin
                  prdata = rx_word;
               end
            end
         end else begin
            waited = 0;
         end
      end
   end

   initial begin : logger
      forever begin
         @(posedge clk);
         if (!rst && psel && penable && pready && n_log < 64) begin
            log_addr[n_log] = paddr;
            log_wr[n_log]   = pwrite;
            log_data[n_log] = pwdata;
            n_log++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setup_slave(input int gp, input int ei, input logic [31:0] rx);
      go_polls   = gp;
      err_idx    = ei;
      rx_word    = rx;
      ctrl_reads = 0;
      n_log      = 0;
   endtask

   task automatic start_req(input logic [23:0] a);
      int k;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      req_valid = 1'b0;
      check("setup_psel_pen", {30'd0, psel, penable}, 32'd2);
      check("setup_paddr", {27'd0, paddr}, 32'h04);
      check("setup_pwdata", pwdata, {8'h03, a});
      check("setup_busy_ready", {30'd0, busy, req_ready}, 32'd2);
      @(negedge clk);
      check("access_psel_pen", {30'd0, psel, penable}, 32'd3);
   endtask

   task automatic wait_rsp(output bit got);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rsp_valid_arrives", {31'd0, got}, 32'd1);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("after_hs_valid_ready_busy", {29'd0, rsp_valid, req_ready, busy}, 32'd2);
   endtask

   typedef struct {
      logic [23:0] addr;
      int          go_polls;
      int          err_idx;
      logic [31:0] rx;
      logic        exp_err;
      logic [31:0] exp_data;
      int          exp_n;
   } vec_t;

   vec_t vecs[8];

   logic [4:0]  seq_addr [8];
   logic        seq_wr   [8];
   logic [31:0] seq_data [8];

   initial begin : main
      bit got;
      int found;
      int n_before;
      int seen;

      vecs[0] = '{24'h001234, 2,  -1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 8};
      vecs[1] = '{24'hABCDEF, 0,  -1, 32'h12345678, 1'b0, 32'h12345678, 6};
      vecs[2] = '{24'hFFFFFF, 3,  -1, 32'hA5A50F0F, 1'b0, 32'hA5A50F0F, 9};
      vecs[3] = '{24'h000001, 0,   3, 32'h11111111, 1'b1, 32'h0, 4};
      vecs[4] = '{24'h000010, 0,   0, 32'h22222222, 1'b1, 32'h0, 1};
      vecs[5] = '{24'h123456, 1,   6, 32'h33333333, 1'b1, 32'h0, 7};
      vecs[6] = '{24'h00FF00, 99, -1, 32'h44444444, 1'b1, 32'h0, 8};
      vecs[7] = '{24'h000003, 0,   4, 32'h55555555, 1'b1, 32'h0, 5};

      seq_addr = '{5'h04, 5'h00, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00};
      seq_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      seq_data = '{32'h03001234, 32'h0, 32'h00002240, 32'h00002340, 32'h0, 32'h0, 32'h0, 32'h0};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", {31'd0, req_ready}, 32'd0);
      check("reset_apb_ctl", {29'd0, psel, penable, pwrite}, 32'd0);
      check("reset_paddr", {27'd0, paddr}, 32'd0);
      check("reset_pwdata", pwdata, 32'd0);
      check("reset_rsp", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         setup_slave(vecs[i].go_polls, vecs[i].err_idx, vecs[i].rx);
         start_req(vecs[i].addr);
         wait_rsp(got);
         if (got) begin
            check($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
            check($sformatf("v%0d_n_access", i), n_log, vecs[i].exp_n);
            check($sformatf("v%0d_tx1", i), log_data[0], {8'h03, vecs[i].addr});
            if (!vecs[i].exp_err && n_log > 0)
               check($sformatf("v%0d_last_rx_read", i), {26'd0, log_wr[n_log-1], log_addr[n_log-1]},
                     32'h00);
            if (i == 0) begin
               for (int j = 0; j < 8; j++) begin
                  check($sformatf("seq%0d_addr", j), {27'd0, log_addr[j]}, {27'd0, seq_addr[j]});
                  check($sformatf("seq%0d_wr", j), {31'd0, log_wr[j]}, {31'd0, seq_wr[j]});
                  if (seq_wr[j]) check($sformatf("seq%0d_data", j), log_data[j], seq_data[j]);
               end
            end
            finish_rsp();
         end
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_no_extra_access", i), n_log, vecs[i].exp_n);
      end

      // Response held off for 5 cycles.
      setup_slave(0, -1, 32'hCAFEF00D);
      start_req(24'h000100);
      wait_rsp(got);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid_ready", {30'd0, rsp_valid, req_ready}, 32'd2);
         check("hold_data", rsp_data, 32'hCAFEF00D);
         @(negedge clk);
      end
      finish_rsp();

      // Request presented while busy is dropped, not queued.
      setup_slave(1, -1, 32'h0BADF00D);
      start_req(24'h001234);
      req_valid = 1'b1;
      req_addr  = 24'hABCDEF;
      repeat (6) @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(got);
      finish_rsp();
      found = 0;
      for (int j = 0; j < n_log; j++) if (log_data[j] == 32'h03ABCDEF) found++;
      check("busy_req_not_sent", found, 0);
      n_before = n_log;
      repeat (3) @(negedge clk);
      check("busy_req_not_queued", n_log, n_before);
      setup_slave(0, -1, 32'h0);
      start_req(24'hABCDEF);
      wait_rsp(got);
      check("represented_tx1", log_data[0], 32'h03ABCDEF);
      finish_rsp();

      // Reset pulse during a CTRL poll access.
      setup_slave(99, -1, 32'h0);
      start_req(24'h000200);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (psel && penable && paddr == 5'h10 && !pwrite) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("poll_access_reached", found, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_psel_pen", {30'd0, psel, penable}, 32'd0);
      check("rst_valid_busy_ready", {29'd0, rsp_valid, busy, req_ready}, 32'd0);
      @(negedge clk);
      check("rst_ready_after", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid || psel) seen++;
         @(negedge clk);
      end
      check("rst_no_rsp_no_apb", seen, 0);
      setup_slave(0, -1, 32'h11223344);
      start_req(24'h000300);
      wait_rsp(got);
      check("post_rst_data", rsp_data, 32'h11223344);
      finish_rsp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
